// File: rtl/muldiv_seq_if.sv
// Issue/result handshake bundle between the execute-stage issue logic and the
// iterative multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] ia;
    logic [XLEN-1:0] ib;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, ia, ib, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, ia, ib, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer: one bit per cycle through a single
// shared XLEN+1-bit add/sub unit (shift-add multiply, restoring divide).
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    // r_hi: product high half / remainder; r_lo: product low half / quotient
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;

    logic              w_accept;
    logic              w_div0;
    logic              w_is_div;
    logic              w_last;
    logic [XLEN:0]     w_as_a;
    logic [XLEN:0]     w_as_b;
    logic              w_as_sub;
    logic [XLEN+1:0]   w_as_sum;

    assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_div0   = bus.op[1] && (bus.ib == '0);
    assign w_is_div = r_op[1];
    assign w_last   = (r_cnt == CNT_W'(1));

    // Shared add/sub: for subtract, the top carry bit set means a >= b.
    always_comb begin
        w_as_a   = {1'b0, r_hi};
        w_as_b   = r_lo[0] ? {1'b0, r_opnd} : '0;
        w_as_sub = 1'b0;
        if (w_is_div) begin
            w_as_a   = {r_hi, r_lo[XLEN-1]};
            w_as_b   = {1'b0, r_opnd};
            w_as_sub = 1'b1;
        end
        w_as_sum = {1'b0, w_as_a} + {1'b0, (w_as_sub ? ~w_as_b : w_as_b)}
                 + {{(XLEN+1){1'b0}}, w_as_sub};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_div0 ? S_DONE : S_RUN;
            S_RUN:  if (w_last) w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_cnt  <= CNT_W'(XLEN);
            if (w_div0) begin
                // RISC-V divide-by-zero: quotient all ones, remainder = dividend
                r_hi   <= bus.ia;
                r_lo   <= '1;
                r_opnd <= bus.ib;
            end else if (bus.op[1]) begin
                r_hi   <= '0;
                r_lo   <= bus.ia;
                r_opnd <= bus.ib;
            end else begin
                r_hi   <= '0;
                r_lo   <= bus.ib;
                r_opnd <= bus.ia;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_is_div) begin
                if (w_as_sum[XLEN+1]) begin
                    r_hi <= w_as_sum[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_as_a[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_as_sum[XLEN:1];
                r_lo <= {w_as_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = (r_state == S_DONE) ? (r_op[0] ? r_hi : r_lo) : '0;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic results, latency,
// result hold under back-pressure, flush and asynchronous reset.
module tb_muldiv_seq;
    localparam int XLEN = 64;
    localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.ia        = '0;
        bus.ib        = '0;
        bus.out_ready = 1'b0;
    endtask

    // Accept one op, scramble the operand inputs, wait for out_valid.
    // lat counts posedges from the accept edge (inclusive) to out_valid.
    task automatic issue_wait(input logic [1:0] op, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.ia = a;
        bus.ib = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = ~op;
        bus.ia = 64'hDEAD_BEEF_0BAD_F00D;
        bus.ib = 64'h0123_4567_89AB_CDEF;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout op=%0d out_valid=%b required 1 within 200 cycles", op, bus.out_valid);
        end
    endtask

    task automatic consume(output logic [XLEN-1:0] res);
        res = bus.result;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume_release out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_lat);
        int lat;
        logic [XLEN-1:0] res;
        issue_wait(op, a, b, lat);
        consume(res);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result got=%h required=%h", name, res, exp_res);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d required=%0d", name, lat, exp_lat);
        end
        $display("op %s a=%h b=%h result=%h latency=%0d", name, a, b, res, lat);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== '0) begin
            errors++;
            $display("FAIL %s in_ready=%b out_valid=%b busy=%b result=%h required 1/0/0/0",
                     name, bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_asserted");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("reset_released");
        $display("reset check done");
    endtask

    task automatic test_mul();
        run_check("MUL_3x5",        OP_MUL,   64'd3, 64'd5, 64'd15, 65);
        run_check("MULHU_3x5",      OP_MULHU, 64'd3, 64'd5, 64'd0,  65);
        run_check("MULHU_max",      OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_check("MUL_max",        OP_MUL,   '1, '1, 64'd1, 65);
        run_check("MUL_shift4",     OP_MUL,   64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00, 65);
        run_check("MULHU_shift4",   OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'h10, 64'h1, 65);
    endtask

    task automatic test_div();
        run_check("DIVU_100_7",     OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
        run_check("REMU_100_7",     OP_REMU, 64'd100, 64'd7, 64'd2,  65);
        run_check("DIVU_by0",       OP_DIVU, 64'd100, 64'd0, '1, 1);
        run_check("REMU_by0",       OP_REMU, 64'd9,   64'd0, 64'd9, 1);
        run_check("DIVU_max_16",    OP_DIVU, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        run_check("REMU_max_16",    OP_REMU, '1, 64'h10, 64'hF, 65);
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        logic [XLEN-1:0] res;
        issue_wait(OP_MUL, 64'd11, 64'd13, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = OP_MULHU;
            bus.ia = 64'd2;
            bus.ib = 64'd2;
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 64'd143 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d out_valid=%b result=%h in_ready=%b required 1/%h/0",
                         i, bus.out_valid, bus.result, bus.in_ready, 64'd143);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume(res);
        checks++;
        if (res !== 64'd143 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release result=%h busy=%b required %h/0", res, bus.busy, 64'd143);
        end
        $display("hold 10 cycles result=%h", res);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_MUL;
        bus.ia = 64'd5;
        bus.ib = 64'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_run in_ready=%b busy=%b out_valid=%b required 1/0/0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result out_valid_cycles=%0d required 0", seen);
        end
        // flush in IDLE with in_valid drops the op
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        bus.op = OP_MUL;
        bus.ia = 64'd3;
        bus.ib = 64'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_drop busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready);
        end
        $display("flush at run cycle 30 done");
        run_check("MUL_after_flush", OP_MUL, 64'd6, 64'd7, 64'd42, 65);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_MUL;
        bus.ia = 64'd8;
        bus.ib = 64'd8;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset_mid_run");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("async_reset_released");
        $display("async reset mid run done");
        run_check("DIVU_after_reset", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_mul();
        test_div();
        test_hold();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
